silly_sweep_ctrl: RTL and testbench



---
 rtl/silly_pkg.sv | 20 ++
 rtl/silly_settle_timer.sv | 28 ++
 rtl/silly_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_silly_sweep_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silly_pkg.sv
// Shared types and defaults for the silly1 sweep sequencer.
package silly_pkg;

  localparam int DATA_W_DEFAULT     = 8;
  localparam int RST_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    DRST,
    APPLY,
    SETTLE,
    REPORT,
    DONE
  } sweep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/silly_settle_timer.sv
// Loadable down-counter shared by the silly1 reset hold and the per-vector settle wait.
module silly_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/silly_sweep_ctrl.sv
// Closed-loop sweep sequencer: resets silly1, walks ui_in from first_val to last_val,
// and hands each (stimulus, response) pair downstream over valid/ready.
module silly_sweep_ctrl
  import silly_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int RST_CYCLES = RST_CYCLES_DEFAULT,
  parameter int SETTLE_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   first_val,
  input  logic [DATA_W-1:0]   last_val,
  input  logic [SETTLE_W-1:0] settle,
  output logic                dut_rst_n,
  output logic [DATA_W-1:0]   dut_ui_in,
  input  logic [DATA_W-1:0]   dut_uo_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_stim,
  output logic [DATA_W-1:0]   res_resp,
  output logic                busy,
  output logic                done
);

  // The timer must hold both the reset hold count and the widest settle value.
  localparam int TW = max_int(SETTLE_W, $clog2(RST_CYCLES + 1));

  sweep_state_t         state;
  sweep_state_t         next_state;
  logic [DATA_W-1:0]    vec;
  logic [DATA_W-1:0]    last_q;
  logic [SETTLE_W-1:0]  settle_q;
  logic                 tmr_load;
  logic                 tmr_en;
  logic [TW-1:0]        tmr_load_val;
  logic                 tmr_zero;

  silly_settle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort overrides every other transition out of a busy state.
  always_comb begin
    next_state   = state;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = '0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state   = DRST;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(RST_CYCLES - 1);
        end
      end
      DRST: begin
        if (tmr_zero) begin
          next_state = APPLY;
        end else begin
          tmr_en = 1'b1;
        end
      end
      APPLY: begin
        next_state   = SETTLE;
        tmr_load     = 1'b1;
        tmr_load_val = TW'(settle_q);
      end
      SETTLE: begin
        if (tmr_zero) begin
          next_state = REPORT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      REPORT: begin
        if (res_ready) begin
          next_state = (vec == last_q) ? DONE : APPLY;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
    end
  end

  // Sweep bookkeeping and the silly1 drive/capture registers only move on real transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec       <= '0;
      last_q    <= '0;
      settle_q  <= '0;
      dut_rst_n <= 1'b0;
      dut_ui_in <= '0;
      res_stim  <= '0;
      res_resp  <= '0;
    end else begin
      if ((state == IDLE) && (next_state == DRST)) begin
        vec      <= first_val;
        last_q   <= last_val;
        settle_q <= settle;
      end
      if ((state == REPORT) && (next_state == APPLY)) begin
        vec <= vec + DATA_W'(1);
      end
      if ((state == APPLY) && (next_state == SETTLE)) begin
        dut_ui_in <= vec;
        dut_rst_n <= 1'b1;
      end else if ((next_state == IDLE) || (next_state == DRST)) begin
        dut_rst_n <= 1'b0;
      end
      if ((state == SETTLE) && (next_state == REPORT)) begin
        res_stim <= vec;
        res_resp <= dut_uo_out;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign res_valid = (state == REPORT);

endmodule

// File: tb/tb_silly_sweep_ctrl.sv
// Self-checking bench for silly_sweep_ctrl: timeline model of the sweep plus directed literal checks.
module tb_silly_sweep_ctrl;

  localparam int DW = 8;
  localparam int RC = 4;
  localparam int SW = 8;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start      = 1'b0;
  logic          abort      = 1'b0;
  logic          res_ready  = 1'b0;
  logic [DW-1:0] first_val  = '0;
  logic [DW-1:0] last_val   = '0;
  logic [SW-1:0] settle     = '0;
  logic [DW-1:0] dut_uo_out = '0;
  logic          dut_rst_n;
  logic [DW-1:0] dut_ui_in;
  logic          res_valid;
  logic [DW-1:0] res_stim;
  logic [DW-1:0] res_resp;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit cmp_en   = 1'b0;

  logic [DW-1:0] hs_stim[$];
  int            hs_cyc[$];

  always #5 clk = ~clk;

  silly_sweep_ctrl #(
    .DATA_W     (DW),
    .RST_CYCLES (RC),
    .SETTLE_W   (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .first_val  (first_val),
    .last_val   (last_val),
    .settle     (settle),
    .dut_rst_n  (dut_rst_n),
    .dut_ui_in  (dut_ui_in),
    .dut_uo_out (dut_uo_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_stim   (res_stim),
    .res_resp   (res_resp),
    .busy       (busy),
    .done       (done)
  );

  // Stand-in for silly1: a fresh unpredictable response every cycle exposes capture timing.
  always @(posedge clk) begin
    cyc++;
    #2;
    dut_uo_out = 8'($urandom);
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_t counts productive cycles since start acceptance; stalls freeze it.
  bit            m_active = 1'b0;
  int            m_t      = 0;
  int            m_n      = 0;
  int            m_s      = 0;
  logic [DW-1:0] m_first  = '0;
  logic [DW-1:0] m_ui     = '0;
  logic [DW-1:0] m_stim   = '0;
  logic [DW-1:0] m_resp   = '0;

  always @(posedge clk) begin
    int k;
    int p;
    logic [DW-1:0] v;
    if (rst) begin
      m_active = 1'b0;
      m_t      = 0;
      m_ui     = '0;
      m_stim   = '0;
      m_resp   = '0;
    end else if (!m_active) begin
      if (start && !abort) begin
        m_active = 1'b1;
        m_t      = 0;
        m_first  = first_val;
        m_s      = int'(settle);
        m_n      = int'(8'(last_val - first_val)) + 1;
      end
    end else if (abort) begin
      m_active = 1'b0;
    end else if (m_t < RC) begin
      m_t++;
    end else begin
      k = (m_t - RC) / (m_s + 3);
      p = (m_t - RC) % (m_s + 3);
      v = m_first + 8'(k);
      if (k == m_n) begin
        m_active = 1'b0;
      end else if (p == 0) begin
        m_ui = v;
        m_t++;
      end else if (p == m_s + 1) begin
        m_stim = v;
        m_resp = dut_uo_out;
        m_t++;
      end else if (p == m_s + 2) begin
        if (res_ready) m_t++;
      end else begin
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    int k;
    int p;
    logic e_valid;
    logic e_done;
    logic e_rstn;
    if (cmp_en) begin
      e_valid = 1'b0;
      e_done  = 1'b0;
      e_rstn  = m_active && (m_t >= RC + 1);
      if (m_active && (m_t >= RC)) begin
        k       = (m_t - RC) / (m_s + 3);
        p       = (m_t - RC) % (m_s + 3);
        e_done  = (k == m_n);
        e_valid = (k < m_n) && (p == m_s + 2);
      end
      checkOutput("busy", 8'(busy), 8'(m_active));
      checkOutput("done", 8'(done), 8'(e_done));
      checkOutput("res_valid", 8'(res_valid), 8'(e_valid));
      checkOutput("dut_rst_n", 8'(dut_rst_n), 8'(e_rstn));
      checkOutput("dut_ui_in", dut_ui_in, m_ui);
      checkOutput("res_stim", res_stim, m_stim);
      checkOutput("res_resp", res_resp, m_resp);
    end
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      hs_stim.push_back(res_stim);
      hs_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] f, input logic [7:0] l, input logic [7:0] s);
    first_val = f;
    last_val  = l;
    settle    = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 8'(busy), 8'd0);
  endtask

  task automatic waitValid(input string name, input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 8'(res_valid), 8'd1);
  endtask

  task automatic checkStims(input string name, input logic [7:0] exp[$]);
    checkOutput({name, "_count"}, 8'(hs_stim.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < hs_stim.size()) checkOutput({name, "_stim"}, hs_stim[i], exp[i]);
    end
  endtask

  initial begin
    int n;
    int d0;
    logic [7:0] exp_q[$];

    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    checkOutput("reset_busy", 8'(busy), 8'd0);
    checkOutput("reset_valid", 8'(res_valid), 8'd0);
    checkOutput("reset_rstn", 8'(dut_rst_n), 8'd0);
    checkOutput("reset_ui", dut_ui_in, 8'h00);
    checkOutput("reset_stim", res_stim, 8'h00);
    rst = 1'b0;
    tick();

    // Basic sweep 01..04, settle 2: done 24 edges after start, results 5 cycles apart.
    $display("[TB] sweep 01..04 settle 2");
    res_ready = 1'b1;
    hs_stim.delete();
    hs_cyc.delete();
    d0 = done_cnt;
    applyStimulus(8'h01, 8'h04, 8'd2);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    checkOutput("t1_done_latency", 8'(n), 8'd24);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    checkStims("t1", exp_q);
    for (int i = 0; i + 1 < hs_cyc.size(); i++) begin
      checkOutput("t1_spacing", 8'(hs_cyc[i+1] - hs_cyc[i]), 8'd5);
    end
    tick();
    checkOutput("t1_busy_after", 8'(busy), 8'd0);
    checkOutput("t1_done_pulses", 8'(done_cnt - d0), 8'd1);

    // Wrapping sweep FE..01 with zero settle.
    $display("[TB] wrap sweep FE..01");
    hs_stim.delete();
    applyStimulus(8'hFE, 8'h01, 8'd0);
    waitIdle("t2_idle", 200);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    checkStims("t2", exp_q);

    // Single vector held under back-pressure.
    $display("[TB] back-pressure on single vector 55");
    res_ready = 1'b0;
    applyStimulus(8'h55, 8'h55, 8'd1);
    waitValid("t3_valid", 100);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("t3_hold_valid", 8'(res_valid), 8'd1);
      checkOutput("t3_hold_stim", res_stim, 8'h55);
    end
    res_ready = 1'b1;
    tick();
    checkOutput("t3_done", 8'(done), 8'd1);
    checkOutput("t3_valid_drop", 8'(res_valid), 8'd0);
    tick();
    checkOutput("t3_idle", 8'(busy), 8'd0);

    // Abort during settle of vector 03.
    $display("[TB] abort in settle of vector 03");
    hs_stim.delete();
    d0 = done_cnt;
    applyStimulus(8'h01, 8'h08, 8'd2);
    n = 0;
    while (dut_ui_in != 8'h03 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("t4_reach_03", dut_ui_in, 8'h03);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4_busy", 8'(busy), 8'd0);
    checkOutput("t4_valid", 8'(res_valid), 8'd0);
    checkOutput("t4_rstn", 8'(dut_rst_n), 8'd0);
    repeat (20) tick();
    checkOutput("t4_no_done", 8'(done_cnt - d0), 8'd0);
    exp_q = '{8'h01, 8'h02};
    checkStims("t4", exp_q);

    // Synchronous reset while a result is pending, then a clean sweep.
    $display("[TB] reset in REPORT");
    res_ready = 1'b0;
    applyStimulus(8'h10, 8'h20, 8'd1);
    waitValid("t5_valid", 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy", 8'(busy), 8'd0);
    checkOutput("t5_valid", 8'(res_valid), 8'd0);
    checkOutput("t5_rstn", 8'(dut_rst_n), 8'd0);
    checkOutput("t5_ui", dut_ui_in, 8'h00);
    checkOutput("t5_stim", res_stim, 8'h00);
    checkOutput("t5_resp", res_resp, 8'h00);
    res_ready = 1'b1;
    hs_stim.delete();
    applyStimulus(8'h10, 8'h12, 8'd0);
    waitIdle("t5_idle", 200);
    exp_q = '{8'h10, 8'h11, 8'h12};
    checkStims("t5", exp_q);

    // start with abort in IDLE, and start pulses while busy, change nothing.
    $display("[TB] ignored starts");
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("t6_start_abort", 8'(busy), 8'd0);
    hs_stim.delete();
    applyStimulus(8'h30, 8'h32, 8'd1);
    for (int i = 0; i < 6; i++) begin
      first_val = 8'h90;
      last_val  = 8'h99;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      tick();
    end
    waitIdle("t6_idle", 200);
    exp_q = '{8'h30, 8'h31, 8'h32};
    checkStims("t6", exp_q);

    // Randomized sweeps against the model.
    $display("[TB] randomized sweeps");
    for (int s = 0; s < 25; s++) begin
      logic [7:0] f;
      f = 8'($urandom);
      applyStimulus(f, f + 8'($urandom_range(0, 7)), 8'($urandom_range(0, 5)));
      n = 0;
      while (busy && n < 2000) begin
        res_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 7) == 0);
        abort     = ($urandom_range(0, 150) == 0);
        first_val = 8'($urandom);
        last_val  = 8'($urandom);
        settle    = 8'($urandom);
        tick();
        n++;
      end
      start = 1'b0;
      abort = 1'b0;
      checkOutput("rand_idle", 8'(busy), 8'd0);
      tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
